// File: rtl/sd_cmd_responder_if.sv
// SD CMD responder bundle: the CMD line as seen by the card, plus the
// command/response handshake towards the card logic.
// slave  = the responder block, master = host line model / card logic.
interface sd_cmd_responder_if;
  logic         cmd_sd;      // CMD line value sampled from the host
  logic         cmd_drv;     // CMD line value driven by the card
  logic         cmd_drv_en;  // drive enable, line is tri-stated when 0
  logic         cmd_valid;   // one-cycle pulse, good command decoded
  logic [5:0]   cmd_idx;     // index of the last good command
  logic [31:0]  cmd_arg;     // argument of the last good command
  logic         crc_err;     // one-cycle pulse, bad CRC7 or end bit
  logic         resp_valid;  // response request from card logic
  logic [1:0]   resp_type;   // 00 none, 01 R1/R6/R7, 10 R2, 11 R3
  logic [127:0] resp_data;   // response content, layout depends on type
  logic         resp_done;   // one-cycle pulse after the end bit
  logic         busy;        // 1 whenever not idle or receiving

  modport slave (
    input  cmd_sd, resp_valid, resp_type, resp_data,
    output cmd_drv, cmd_drv_en, cmd_valid, cmd_idx, cmd_arg,
           crc_err, resp_done, busy
  );

  modport master (
    output cmd_sd, resp_valid, resp_type, resp_data,
    input  cmd_drv, cmd_drv_en, cmd_valid, cmd_idx, cmd_arg,
           crc_err, resp_done, busy
  );
endinterface

// File: rtl/sd_cmd_responder.sv
// Card-side end of the SD CMD line. Receives 48-bit host commands,
// validates start/transmission/end bits and CRC7, presents index and
// argument to card logic, then sends the requested response (48-bit with
// CRC7, 48-bit R3 without CRC, or 136-bit R2) after NCR idle clocks.
// Build option: define SD_CMD_CRC_CHECK_EN to compare the received CRC7;
// without it only the end bit of a command is checked.
module sd_cmd_responder #(
  parameter int NCR          = 2,   // clocks from accept to start bit, 2..64
  parameter int RESP_TIMEOUT = 64   // clocks to wait for a response request
) (
  input  logic clk_sd,
  input  logic rst_n,
  sd_cmd_responder_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RX    = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NCR   = 3'd4;
  localparam logic [2:0] ST_TX    = 3'd5;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_R1   = 2'b01;
  localparam logic [1:0] RESP_R2   = 2'b10;
  localparam logic [1:0] RESP_R3   = 2'b11;

  localparam logic [7:0] NCR_LAST  = 8'(NCR - 1);
  localparam logic [7:0] WAIT_LAST = 8'(RESP_TIMEOUT - 1);

  logic [2:0]   state_reg, state_next;
  logic [7:0]   cnt_reg, cnt_next;          // RX bits / wait / NCR / TX bits
  logic [46:0]  rx_shift_reg, rx_shift_next;
  logic [6:0]   crc_reg, crc_next;          // shared by RX check and TX generation
  logic [135:0] tx_shift_reg, tx_shift_next;
  logic [1:0]   resp_type_reg, resp_type_next;
  logic         drv_reg, drv_next;
  logic         drv_en_reg, drv_en_next;
  logic [5:0]   idx_reg, idx_next;
  logic [31:0]  arg_reg, arg_next;
  logic         cmd_valid_reg, cmd_valid_next;
  logic         crc_err_reg, crc_err_next;
  logic         resp_done_reg, resp_done_next;

  logic [47:0]  frame;       // received frame including the bit on the line now
  logic         crc_ok;
  logic         frame_ok;
  logic         tx_bit;      // bit to drive at the coming edge while in TX
  logic [7:0]   tx_len;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
    logic fb;
    fb = d ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  assign frame = {rx_shift_reg, bus.cmd_sd};

`ifdef SD_CMD_CRC_CHECK_EN
  assign crc_ok = (crc_reg == frame[7:1]);
`else
  // CRC field is received but deliberately not compared in this build.
  assign crc_ok = 1'b1;
  logic unused_crc_field;
  assign unused_crc_field = ^frame[7:1];
`endif

  // Start bit 0, transmission bit 1, end bit 1 and (optionally) CRC7 match.
  assign frame_ok = ~frame[47] & frame[46] & frame[0] & crc_ok;

  // For 48-bit responses with CRC the bits 40..46 come from the CRC register.
  assign tx_bit = (resp_type_reg == RESP_R1 && cnt_reg >= 8'd40 && cnt_reg <= 8'd46)
                  ? crc_reg[6] : tx_shift_reg[135];
  assign tx_len = (resp_type_reg == RESP_R2) ? 8'd136 : 8'd48;

  // R2 content already carries its own CRC in bits 7..1; bit 0 is not sent.
  logic unused_resp_lsb;
  assign unused_resp_lsb = bus.resp_data[0];

  // Next-state and datapath decode for the whole receive/respond cycle.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rx_shift_next  = rx_shift_reg;
    crc_next       = crc_reg;
    tx_shift_next  = tx_shift_reg;
    resp_type_next = resp_type_reg;
    drv_next       = drv_reg;
    drv_en_next    = drv_en_reg;
    idx_next       = idx_reg;
    arg_next       = arg_reg;
    cmd_valid_next = 1'b0;
    crc_err_next   = 1'b0;
    resp_done_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        crc_next = '0;
        if (!bus.cmd_sd) begin
          // Start bit leaves the CRC at zero, so no step is needed here.
          state_next    = ST_RX;
          cnt_next      = 8'd1;
          rx_shift_next = frame[46:0];
        end
      end

      ST_RX: begin
        rx_shift_next = frame[46:0];
        cnt_next      = cnt_reg + 8'd1;
        if (cnt_reg < 8'd40) begin
          crc_next = crc7_step(crc_reg, bus.cmd_sd);
        end
        if (cnt_reg == 8'd1 && !bus.cmd_sd) begin
          // Transmission bit 0 means this is not a host command.
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == 8'd47) begin
          state_next = ST_CHECK;
          cnt_next   = '0;
          if (frame_ok) begin
            cmd_valid_next = 1'b1;
            idx_next       = frame[45:40];
            arg_next       = frame[39:8];
          end else begin
            crc_err_next = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        // The verdict pulse is visible during this cycle.
        state_next = cmd_valid_reg ? ST_WAIT : ST_IDLE;
        cnt_next   = '0;
      end

      ST_WAIT: begin
        if (bus.resp_valid) begin
          if (bus.resp_type == RESP_NONE) begin
            state_next = ST_IDLE;
          end else begin
            state_next     = ST_NCR;
            cnt_next       = '0;
            crc_next       = '0;
            resp_type_next = bus.resp_type;
            case (bus.resp_type)
              RESP_R1: tx_shift_next = {2'b00, bus.resp_data[37:32], bus.resp_data[31:0],
                                        7'd0, 1'b1, 88'd0};
              RESP_R3: tx_shift_next = {2'b00, 6'h3F, bus.resp_data[31:0],
                                        7'h7F, 1'b1, 88'd0};
              RESP_R2: tx_shift_next = {2'b00, 6'h3F, bus.resp_data[127:1], 1'b1};
              default: tx_shift_next = '1;
            endcase
          end
        end else if (cnt_reg == WAIT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_NCR: begin
        if (cnt_reg == NCR_LAST) begin
          // Start bit goes out on the NCR-th edge after acceptance.
          state_next    = ST_TX;
          drv_next      = tx_shift_reg[135];
          drv_en_next   = 1'b1;
          tx_shift_next = {tx_shift_reg[134:0], 1'b0};
          crc_next      = crc7_step(crc_reg, tx_shift_reg[135]);
          cnt_next      = 8'd1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_TX: begin
        if (cnt_reg == tx_len) begin
          state_next     = ST_IDLE;
          drv_next       = 1'b1;
          drv_en_next    = 1'b0;
          resp_done_next = 1'b1;
          crc_next       = '0;
          cnt_next       = '0;
        end else begin
          drv_next      = tx_bit;
          tx_shift_next = {tx_shift_reg[134:0], 1'b0};
          cnt_next      = cnt_reg + 8'd1;
          if (cnt_reg < 8'd40) begin
            crc_next = crc7_step(crc_reg, tx_bit);
          end else begin
            crc_next = {crc_reg[5:0], 1'b0};
          end
        end
      end

      default: begin
        state_next  = ST_IDLE;
        drv_next    = 1'b1;
        drv_en_next = 1'b0;
      end
    endcase
  end

  // State registers; reset releases the line at once and drops any frame.
  always_ff @(posedge clk_sd or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rx_shift_reg  <= '0;
      crc_reg       <= '0;
      tx_shift_reg  <= '0;
      resp_type_reg <= RESP_NONE;
      drv_reg       <= 1'b1;
      drv_en_reg    <= 1'b0;
      idx_reg       <= '0;
      arg_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      crc_err_reg   <= 1'b0;
      resp_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rx_shift_reg  <= rx_shift_next;
      crc_reg       <= crc_next;
      tx_shift_reg  <= tx_shift_next;
      resp_type_reg <= resp_type_next;
      drv_reg       <= drv_next;
      drv_en_reg    <= drv_en_next;
      idx_reg       <= idx_next;
      arg_reg       <= arg_next;
      cmd_valid_reg <= cmd_valid_next;
      crc_err_reg   <= crc_err_next;
      resp_done_reg <= resp_done_next;
    end
  end

  assign bus.cmd_drv    = drv_reg;
  assign bus.cmd_drv_en = drv_en_reg;
  assign bus.cmd_valid  = cmd_valid_reg;
  assign bus.cmd_idx    = idx_reg;
  assign bus.cmd_arg    = arg_reg;
  assign bus.crc_err    = crc_err_reg;
  assign bus.resp_done  = resp_done_reg;
  assign bus.busy       = (state_reg != ST_IDLE) && (state_reg != ST_RX);

endmodule
